// File: rtl/wb_retire_queue_stage_pkg.sv
// Shared widths, bus field offsets and entry layout for the write-back retire queue.
package wb_pkg;

  localparam int unsigned WB_DW    = 32;
  localparam int unsigned WB_AW    = 5;
  localparam int unsigned WB_PCW   = 32;
  localparam int unsigned WB_DEPTH = 2;

  localparam int unsigned WB_BUS_W = WB_PCW + 1 + WB_AW + WB_DW;

  // Bus is {pc, gr_we, dest, result}, MSB first
  localparam int unsigned RES_LSB  = 0;
  localparam int unsigned DEST_LSB = RES_LSB + WB_DW;
  localparam int unsigned WE_BIT   = DEST_LSB + WB_AW;
  localparam int unsigned PC_LSB   = WE_BIT + 1;

  typedef struct packed {
    logic [WB_PCW-1:0] pc;
    logic              gr_we;
    logic [WB_AW-1:0]  dest;
    logic [WB_DW-1:0]  result;
  } wb_entry_t;

endpackage

// File: rtl/wb_retire_queue_stage_if.sv
// MEM->WB handshake, RF write port and ID forwarding lookup. Debug trace ports exist
// only when WB_DEBUG_TRACE_EN is defined.
interface wb_retire_queue_stage_if
  import wb_pkg::*;
#(
  parameter int unsigned DW  = WB_DW,
  parameter int unsigned AW  = WB_AW,
  parameter int unsigned PCW = WB_PCW
);
  localparam int unsigned BW = PCW + 1 + AW + DW;

  logic          ms_to_ws_valid;
  logic [BW-1:0] ms_to_ws_bus;
  logic          ws_allowin;
  logic          rf_port_busy;
  logic          rf_we;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;
  logic [AW-1:0] ds_query_addr;
  logic          ds_fwd_hit;
  logic [DW-1:0] ds_fwd_data;
  logic          ws_empty;

`ifdef WB_DEBUG_TRACE_EN
  logic [PCW-1:0] debug_wb_pc;
  logic [3:0]     debug_wb_rf_we;
  logic [AW-1:0]  debug_wb_rf_wnum;
  logic [DW-1:0]  debug_wb_rf_wdata;
  logic [31:0]    retire_cnt;

  modport slave (
    input  ms_to_ws_valid, ms_to_ws_bus, rf_port_busy, ds_query_addr,
    output ws_allowin, rf_we, rf_waddr, rf_wdata, ds_fwd_hit, ds_fwd_data, ws_empty,
    output debug_wb_pc, debug_wb_rf_we, debug_wb_rf_wnum, debug_wb_rf_wdata, retire_cnt
  );
  modport master (
    output ms_to_ws_valid, ms_to_ws_bus, rf_port_busy, ds_query_addr,
    input  ws_allowin, rf_we, rf_waddr, rf_wdata, ds_fwd_hit, ds_fwd_data, ws_empty,
    input  debug_wb_pc, debug_wb_rf_we, debug_wb_rf_wnum, debug_wb_rf_wdata, retire_cnt
  );
`else
  modport slave (
    input  ms_to_ws_valid, ms_to_ws_bus, rf_port_busy, ds_query_addr,
    output ws_allowin, rf_we, rf_waddr, rf_wdata, ds_fwd_hit, ds_fwd_data, ws_empty
  );
  modport master (
    output ms_to_ws_valid, ms_to_ws_bus, rf_port_busy, ds_query_addr,
    input  ws_allowin, rf_we, rf_waddr, rf_wdata, ds_fwd_hit, ds_fwd_data, ws_empty
  );
`endif

endinterface

// File: rtl/wb_retire_queue_stage_fifo.sv
// In-order retire storage: head/tail/count, per-entry valid, all entries exposed for
// the forwarding search. Payloads are not reset; valid bits gate every use.
module wb_retire_fifo
  import wb_pkg::*;
#(
  parameter int unsigned DW    = WB_DW,
  parameter int unsigned AW    = WB_AW,
  parameter int unsigned PCW   = WB_PCW,
  parameter int unsigned DEPTH = WB_DEPTH,
  localparam int unsigned BW    = PCW + 1 + AW + DW,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             enq,
  input  logic [BW-1:0]    enq_data,
  input  logic             deq,
  output logic             full,
  output logic             empty,
  output logic [PTR_W-1:0] head,
  output logic [DEPTH-1:0] entry_valid,
  output logic [DEPTH-1:0] entry_we,
  output logic [AW-1:0]    entry_dest   [DEPTH],
  output logic [DW-1:0]    entry_result [DEPTH],
  output logic [PCW-1:0]   head_pc
);
  localparam int unsigned L_DEST_LSB = DW;
  localparam int unsigned L_WE_BIT   = DW + AW;
  localparam int unsigned L_PC_LSB   = DW + AW + 1;

  logic [BW-1:0]    mem [DEPTH];
  logic [DEPTH-1:0] vld_q;
  logic [PTR_W-1:0] head_q;
  logic [PTR_W-1:0] tail_q;
  logic [CNT_W-1:0] count_q;

  // Pointers, occupancy and per-entry valid
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      vld_q   <= '0;
    end else begin
      if (enq) begin
        tail_q        <= tail_q + PTR_W'(1);
        vld_q[tail_q] <= 1'b1;
      end
      if (deq) begin
        head_q        <= head_q + PTR_W'(1);
        vld_q[head_q] <= 1'b0;
      end
      if (enq && !deq)      count_q <= count_q + CNT_W'(1);
      else if (!enq && deq) count_q <= count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (enq) mem[tail_q] <= enq_data;
  end

  assign full        = (count_q == CNT_W'(DEPTH));
  assign empty       = (count_q == '0);
  assign head        = head_q;
  assign entry_valid = vld_q;
  assign head_pc     = mem[head_q][L_PC_LSB +: PCW];

  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    assign entry_we[i]     = mem[i][L_WE_BIT];
    assign entry_dest[i]   = mem[i][L_DEST_LSB +: AW];
    assign entry_result[i] = mem[i][0 +: DW];
  end

endmodule

// File: rtl/wb_retire_queue_stage.sv
// Write-back stage: MEM handshake, in-order retire queue, RF write port and ID
// forwarding over pending writes. Optional trace outputs under WB_DEBUG_TRACE_EN.
module wb_retire_queue_stage
  import wb_pkg::*;
#(
  parameter int unsigned DW    = WB_DW,
  parameter int unsigned AW    = WB_AW,
  parameter int unsigned PCW   = WB_PCW,
  parameter int unsigned DEPTH = WB_DEPTH
) (
  input logic                    clk,
  input logic                    resetn,
  wb_retire_queue_stage_if.slave wb
);
  localparam int unsigned BW         = PCW + 1 + AW + DW;
  localparam int unsigned PTR_W      = $clog2(DEPTH);
  localparam int unsigned L_DEST_LSB = DW;
  localparam int unsigned L_WE_BIT   = DW + AW;

  logic             full;
  logic             empty;
  logic             enq;
  logic             deq;
  logic [BW-1:0]    enq_data;
  logic [PTR_W-1:0] head;
  logic [DEPTH-1:0] entry_valid;
  logic [DEPTH-1:0] entry_we;
  logic [AW-1:0]    entry_dest   [DEPTH];
  logic [DW-1:0]    entry_result [DEPTH];
  logic [PCW-1:0]   head_pc;
  logic             rf_we;
  logic [PTR_W-1:0] idx;
  logic             fwd_hit;
  logic [DW-1:0]    fwd_data;

  assign enq = wb.ms_to_ws_valid && !full;
  assign deq = !empty && !wb.rf_port_busy;

  // Writes to r0 are stored as non-writing so they never reach the RF or forwarding
  always_comb begin
    enq_data = wb.ms_to_ws_bus;
    if (wb.ms_to_ws_bus[L_DEST_LSB +: AW] == '0) enq_data[L_WE_BIT] = 1'b0;
  end

  wb_retire_fifo #(
    .DW(DW), .AW(AW), .PCW(PCW), .DEPTH(DEPTH)
  ) u_fifo (
    .clk          (clk),
    .resetn       (resetn),
    .enq          (enq),
    .enq_data     (enq_data),
    .deq          (deq),
    .full         (full),
    .empty        (empty),
    .head         (head),
    .entry_valid  (entry_valid),
    .entry_we     (entry_we),
    .entry_dest   (entry_dest),
    .entry_result (entry_result),
    .head_pc      (head_pc)
  );

  assign rf_we = !empty && entry_we[head] && !wb.rf_port_busy;

  always_comb begin
    wb.rf_we    = rf_we;
    wb.rf_waddr = rf_we ? entry_dest[head]   : '0;
    wb.rf_wdata = rf_we ? entry_result[head] : '0;
  end

  // Walk oldest to youngest so the last match wins; the retiring head still counts
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    idx      = head;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      idx = head + PTR_W'(k);
      if (wb.ds_query_addr != '0 && entry_valid[idx] && entry_we[idx] &&
          entry_dest[idx] == wb.ds_query_addr) begin
        fwd_hit  = 1'b1;
        fwd_data = entry_result[idx];
      end
    end
  end

  assign wb.ds_fwd_hit  = fwd_hit;
  assign wb.ds_fwd_data = fwd_data;
  assign wb.ws_allowin  = !full;
  assign wb.ws_empty    = empty;

`ifdef WB_DEBUG_TRACE_EN
  logic [31:0] retire_cnt_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)  retire_cnt_q <= '0;
    else if (deq) retire_cnt_q <= retire_cnt_q + 32'd1;
  end

  assign wb.retire_cnt        = retire_cnt_q;
  assign wb.debug_wb_pc       = rf_we ? head_pc : '0;
  assign wb.debug_wb_rf_we    = {4{rf_we}};
  assign wb.debug_wb_rf_wnum  = wb.rf_waddr;
  assign wb.debug_wb_rf_wdata = wb.rf_wdata;
`else
  logic [PCW-1:0] unused_head_pc;
  assign unused_head_pc = head_pc;
`endif

endmodule

// File: tb/tb_wb_retire_queue_stage.sv
// Scoreboard bench for wb_retire_queue_stage: expected RF writes are queued at
// acceptance and checked by an independent monitor on every falling edge.
module tb_wb_retire_queue_stage;
  import wb_pkg::*;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  wb_retire_queue_stage_if #(.DW(32), .AW(5), .PCW(32)) wb ();

  wb_retire_queue_stage #(.DW(32), .AW(5), .PCW(32), .DEPTH(2)) dut (
    .clk    (clk),
    .resetn (resetn),
    .wb     (wb)
  );

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t sb[$];
  int  compared   = 0;
  int  mismatched = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every RF write must match the oldest expected write; idle port is zero
  initial begin : monitor
    wr_t e;
    forever begin
      @(negedge clk);
      if (wb.rf_we === 1'b1) begin
        compared++;
        if (sb.size() == 0) begin
          mismatched++;
          $display("FAIL rf_write_unexpected: got addr %0d data 0x%0h, expected no write",
                   wb.rf_waddr, wb.rf_wdata);
        end else begin
          e = sb.pop_front();
          if (wb.rf_waddr !== e.addr || wb.rf_wdata !== e.data) begin
            mismatched++;
            $display("FAIL rf_write: got addr %0d data 0x%0h, expected addr %0d data 0x%0h",
                     wb.rf_waddr, wb.rf_wdata, e.addr, e.data);
          end
        end
      end else begin
        chk("rf_idle_zero", 64'({wb.rf_waddr, wb.rf_wdata}), 64'd0);
      end
    end
  end

  // Present one instruction and hold it until accepted; valid stays high on return
  task automatic send(input logic [31:0] pc, input logic we, input logic [4:0] dest,
                      input logic [31:0] res, input bit expect_wr, output int waits);
    wb_entry_t e;
    e.pc = pc; e.gr_we = we; e.dest = dest; e.result = res;
    wb.ms_to_ws_bus   = e;
    wb.ms_to_ws_valid = 1'b1;
    waits = 0;
    @(negedge clk);
    while (wb.ws_allowin !== 1'b1 && waits < 20) begin
      waits++;
      @(negedge clk);
    end
    if (wb.ws_allowin !== 1'b1) begin
      compared++;
      mismatched++;
      $display("FAIL accept_timeout: got ws_allowin %b after %0d cycles, expected 1",
               wb.ws_allowin, waits);
    end else if (expect_wr) begin
      sb.push_back({dest, res});
    end
    @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got no finish by 200000, expected finish");
    $fatal(1);
  end

  initial begin : stim
    int w;
    resetn = 1'b0;
    wb.ms_to_ws_valid = 1'b0;
    wb.ms_to_ws_bus   = '0;
    wb.rf_port_busy   = 1'b0;
    wb.ds_query_addr  = '0;

    // Reset state
    #3;
    chk("rst_allowin", 64'(wb.ws_allowin), 64'd1);
    chk("rst_rf_we", 64'(wb.rf_we), 64'd0);
    chk("rst_waddr", 64'(wb.rf_waddr), 64'd0);
    chk("rst_wdata", 64'(wb.rf_wdata), 64'd0);
    chk("rst_fwd_hit", 64'(wb.ds_fwd_hit), 64'd0);
    chk("rst_fwd_data", 64'(wb.ds_fwd_data), 64'd0);
    chk("rst_empty", 64'(wb.ws_empty), 64'd1);
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;

    // Single instruction: written the cycle after acceptance
    send(32'h1c000000, 1'b1, 5'd3, 32'hDEADBEEF, 1'b1, w);
    wb.ms_to_ws_valid = 1'b0;
    @(negedge clk);
    chk("single_rf_we", 64'(wb.rf_we), 64'd1);
    chk("single_waddr", 64'(wb.rf_waddr), 64'd3);
    chk("single_wdata", 64'(wb.rf_wdata), 64'hDEADBEEF);
    @(negedge clk);
    chk("single_empty_after", 64'(wb.ws_empty), 64'd1);

    // Back-to-back: never a wait cycle at full throughput
    @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      send(32'h1c000100 + 32'(4 * i), 1'b1, 5'(8 + i), 32'h100 + 32'(i), 1'b1, w);
      chk("b2b_wait", 64'(w), 64'd0);
    end
    wb.ms_to_ws_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("b2b_drained", 64'(sb.size()), 64'd0);

    // Backpressure: port busy for 4 edges while MEM streams
    @(posedge clk);
    #1;
    wb.rf_port_busy = 1'b1;
    fork
      begin
        repeat (4) @(posedge clk);
        #1 wb.rf_port_busy = 1'b0;
      end
    join_none
    send(32'h1c000200, 1'b1, 5'd10, 32'hA0, 1'b1, w);
    send(32'h1c000204, 1'b1, 5'd11, 32'hB0, 1'b1, w);
    wb.ms_to_ws_valid = 1'b0;
    @(negedge clk);
    chk("bp_full_allowin", 64'(wb.ws_allowin), 64'd0);
    chk("bp_full_rf_we", 64'(wb.rf_we), 64'd0);
    send(32'h1c000208, 1'b1, 5'd12, 32'hC0, 1'b1, w);
    chk("bp_wait_c", 64'(w), 64'd2);
    send(32'h1c00020c, 1'b1, 5'd13, 32'hD0, 1'b1, w);
    wb.ms_to_ws_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("bp_drained", 64'(sb.size()), 64'd0);

    // Forwarding priority: youngest matching entry wins
    @(posedge clk);
    #1;
    wb.rf_port_busy = 1'b1;
    send(32'h1c000300, 1'b1, 5'd5, 32'h11, 1'b1, w);
    send(32'h1c000304, 1'b1, 5'd5, 32'h22, 1'b1, w);
    wb.ms_to_ws_valid = 1'b0;
    wb.ds_query_addr  = 5'd5;
    @(negedge clk);
    chk("fwd_q5_hit", 64'(wb.ds_fwd_hit), 64'd1);
    chk("fwd_q5_data", 64'(wb.ds_fwd_data), 64'h22);
    wb.ds_query_addr = 5'd0;
    #1;
    chk("fwd_q0_hit", 64'(wb.ds_fwd_hit), 64'd0);
    chk("fwd_q0_data", 64'(wb.ds_fwd_data), 64'd0);
    wb.ds_query_addr = 5'd6;
    #1;
    chk("fwd_q6_hit", 64'(wb.ds_fwd_hit), 64'd0);
    chk("fwd_q6_data", 64'(wb.ds_fwd_data), 64'd0);
    @(posedge clk);
    #1;
    wb.ds_query_addr = 5'd5;
    wb.rf_port_busy  = 1'b0;
    @(negedge clk);
    chk("fwd_retiring_rf_we", 64'(wb.rf_we), 64'd1);
    chk("fwd_retiring_hit", 64'(wb.ds_fwd_hit), 64'd1);
    chk("fwd_retiring_data", 64'(wb.ds_fwd_data), 64'h22);
    @(negedge clk);
    chk("fwd_last_hit", 64'(wb.ds_fwd_hit), 64'd1);
    chk("fwd_last_data", 64'(wb.ds_fwd_data), 64'h22);
    @(negedge clk);
    chk("fwd_gone_hit", 64'(wb.ds_fwd_hit), 64'd0);

    // r0 write and non-writing entry: no RF write, one dequeue cycle each
    @(posedge clk);
    #1;
    send(32'h1c000400, 1'b1, 5'd0, 32'hAA, 1'b0, w);
    send(32'h1c000404, 1'b0, 5'd7, 32'hBB, 1'b0, w);
    wb.ms_to_ws_valid = 1'b0;
    wb.ds_query_addr  = 5'd7;
    @(negedge clk);
    chk("r0_one_left", 64'(wb.ws_empty), 64'd0);
    chk("r0_rf_we", 64'(wb.rf_we), 64'd0);
    chk("nowe_fwd_hit", 64'(wb.ds_fwd_hit), 64'd0);
    @(negedge clk);
    chk("r0_empty", 64'(wb.ws_empty), 64'd1);

    // Reset mid-operation discards pending writes
    @(posedge clk);
    #1;
    wb.rf_port_busy = 1'b1;
    send(32'h1c000500, 1'b1, 5'd20, 32'h55, 1'b0, w);
    send(32'h1c000504, 1'b1, 5'd21, 32'h66, 1'b0, w);
    wb.ms_to_ws_valid = 1'b0;
    wb.ds_query_addr  = 5'd20;
    @(negedge clk);
    chk("mid_pending", 64'(wb.ws_empty), 64'd0);
    chk("mid_fwd_hit", 64'(wb.ds_fwd_hit), 64'd1);
    chk("mid_fwd_data", 64'(wb.ds_fwd_data), 64'h55);
    #2 resetn = 1'b0;
    #1;
    chk("mid_rst_allowin", 64'(wb.ws_allowin), 64'd1);
    chk("mid_rst_empty", 64'(wb.ws_empty), 64'd1);
    chk("mid_rst_rf_we", 64'(wb.rf_we), 64'd0);
    chk("mid_rst_fwd_hit", 64'(wb.ds_fwd_hit), 64'd0);
    chk("mid_rst_fwd_data", 64'(wb.ds_fwd_data), 64'd0);
    wb.rf_port_busy = 1'b0;
    @(posedge clk);
    #1 resetn = 1'b1;
    repeat (4) @(negedge clk);
    chk("post_rst_allowin", 64'(wb.ws_allowin), 64'd1);
    chk("post_rst_empty", 64'(wb.ws_empty), 64'd1);

    chk("sb_final_drained", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/wb_retire_queue_stage.md
Name: wb_retire_queue_stage

Overview:
Parametrised write-back stage for the 5-stage pipeline. Accepts retiring instructions from MEM through the valid/allowin handshake and buffers them in a DEPTH-entry in-order queue. Drains one entry per cycle into the register-file write port, which can be blocked by a shared-port writer. Gives ID a combinational forwarding lookup over all pending writes, so ID does not stall on a WB-resident result.

Parameters:
DW, 32, register data width
AW, 5, register address width
PCW, 32, PC width
DEPTH, 2, queue entries; power of two, >= 2

Ports:
clk  input  1  clock
resetn  input  1  reset
ms_to_ws_valid  input  1  MEM holds a valid instruction
ms_to_ws_bus  input  PCW+1+AW+DW  {pc, gr_we, dest, result}, MSB first (70 bits at defaults)
ws_allowin  output  1  WB accepts this cycle
rf_port_busy  input  1  RF write port taken by another writer this cycle
rf_we  output  1  RF write enable
rf_waddr  output  AW  RF write address
rf_wdata  output  DW  RF write data
ds_query_addr  input  AW  ID source register to look up
ds_fwd_hit  output  1  a pending write to ds_query_addr exists
ds_fwd_data  output  DW  data of the youngest matching pending write
ws_empty  output  1  queue holds no entries

Behaviour:
- Reset: clk/resetn only; resetn is asynchronous, active-low. On reset, count=0, head=tail=0, and all entry valid/gr_we bits clear. Outputs during reset: ws_allowin=1, rf_we=0, rf_waddr=0, rf_wdata=0, ds_fwd_hit=0, ds_fwd_data=0, ws_empty=1. Entry payloads need no reset.
- Reset mid-operation discards every pending entry. Those writes are lost and rf_we stays 0.
- ws_allowin = (count < DEPTH). It depends on registered state only: no combinational path from rf_port_busy or ms_to_ws_valid.
- Enqueue when ms_to_ws_valid && ws_allowin.
  - Store the bus at tail, then tail++ (wraps mod DEPTH).
  - If dest==0, store gr_we as 0 (writes to r0 are never issued).
- Dequeue when count>0 && !rf_port_busy, then head++ (wraps mod DEPTH).
  - Entries with gr_we=0 still consume one dequeue cycle.
- rf_we = (count>0) && head.gr_we && !rf_port_busy.
- rf_waddr and rf_wdata come from the head entry when rf_we=1 and are 0 otherwise.
- Latency: an instruction accepted at edge N is written at edge N+1 if the queue was empty and the port is free. Each busy cycle delays it by one more.
- Simultaneous enqueue and dequeue: count is unchanged, and both pointers advance.
- When full (count==DEPTH), ws_allowin=0 even if a dequeue happens this cycle. Acceptance resumes the cycle after.
- Throughput: one instruction per cycle with DEPTH>=2 and the port never busy.
- Forwarding:
  - ds_fwd_hit=1 iff ds_query_addr!=0 and some valid entry has gr_we=1 and dest==ds_query_addr.
  - ds_fwd_data is the result of the youngest such entry (closest to tail); 0 when there is no hit.
  - The head entry retiring this cycle still reports a hit, because the RF holds the value only after the edge.
  - The incoming MEM bus is not searched.
- ws_empty = (count==0).

Optional Feature:
WB_DEBUG_TRACE_EN.
- Defined: adds outputs debug_wb_pc[PCW], debug_wb_rf_we[4], debug_wb_rf_wnum[AW], debug_wb_rf_wdata[DW], and retire_cnt[32].
  - The debug fields mirror the head entry on cycles where rf_we=1. debug_wb_rf_we={4{rf_we}}, and the other fields are 0 when rf_we=0.
  - retire_cnt increments on every dequeue, wraps at 2^32, and resets to 0.
- Undefined: these ports and the counter are absent. Functional behaviour is identical.

Decomposition:
- Package wb_pkg holds:
  - WB_BUS_W = PCW+1+AW+DW;
  - the field offsets RES_LSB, DEST_LSB, WE_BIT, PC_LSB;
  - the entry typedef {pc, gr_we, dest, result}.
- Sub-module wb_retire_fifo holds the storage, head/tail/count and full/empty logic, and exposes all entries for the forwarding search.
- The top level holds the handshake, RF port logic, forwarding priority mux and debug trace.

Test Plan:
- Single instruction: pc=0x1c000000, dest=3, result=0xDEADBEEF, port free -> rf_we=1, waddr=3, wdata=0xDEADBEEF the cycle after acceptance; ws_empty=1 afterwards.
- Back-to-back: 8 instructions on consecutive cycles, port free -> 8 RF writes on consecutive cycles in order; ws_allowin stays 1.
- Backpressure: hold rf_port_busy=1 for 4 cycles while MEM streams -> ws_allowin drops after DEPTH=2 accepts; after release, entries drain in order with no loss or duplicates.
- Forwarding priority: queue holds r5=0x11 (older) and r5=0x22 (younger), query=5 -> hit=1, data=0x22; query=0 -> hit=0; query=6 -> hit=0.
- r0 and non-writing entries: dest=0 with gr_we=1, then gr_we=0 with dest=7 -> rf_we stays 0 for both, and each entry dequeues in one cycle.
- Reset mid-operation: assert resetn=0 with 2 entries pending -> outputs immediately at reset values; after release, no write from the old entries and ws_allowin=1.
